// File: rtl/test_led_ctrl.sv
// LED pattern generator for the board LED bank.
// A 2-bit mode select picks one of four 8-bit patterns (binary count,
// rotate-left running light, rotate-right running light, all-LED flash),
// which advances once every DIV_COUNT clocks.
//
// mode        | meaning
// ------------+-------------------------------------------------
// MODE_COUNT  | LED counts up by one per step, wraps FF -> 00
// MODE_ROTL   | single lit LED runs left, 80 -> 01
// MODE_ROTR   | single lit LED runs right, 01 -> 80
// MODE_FLASH  | whole bank toggles, FF <-> 00
//
// Any change of the mode select reloads that mode's seed pattern and restarts
// the step interval, so a re-selected mode always starts fresh.
module test_led_ctrl #(
  parameter int DIV_COUNT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] choose,
  output logic [7:0] LED
);

  // Counter must be at least one bit wide, even when DIV_COUNT is 1.
  localparam int CNT_W = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_COUNT - 1);

  typedef enum logic [1:0] {
    MODE_COUNT = 2'd0,
    MODE_ROTL  = 2'd1,
    MODE_ROTR  = 2'd2,
    MODE_FLASH = 2'd3
  } mode_t;

  mode_t            mode;
  logic [CNT_W-1:0] div_cnt;
  logic             tick;
  logic             mode_change;
  logic [7:0]       led_seed;
  logic [7:0]       led_step;

  // Step tick fires on the last cycle of each divider interval.
  assign tick        = (div_cnt == CNT_LAST);
  assign mode_change = (choose != mode);

  // Seed pattern of the newly requested mode.
  always_comb begin
    led_seed = 8'h00;
    case (choose)
      2'd0:    led_seed = 8'h00;
      2'd1:    led_seed = 8'h01;
      2'd2:    led_seed = 8'h80;
      default: led_seed = 8'hFF;
    endcase
  end

  // Next pattern value in the current mode.
  always_comb begin
    led_step = LED;
    case (mode)
      MODE_COUNT: led_step = LED + 8'd1;
      MODE_ROTL:  led_step = {LED[6:0], LED[7]};
      MODE_ROTR:  led_step = {LED[0], LED[7:1]};
      default:    led_step = ~LED;
    endcase
  end

  // Mode register, step divider and LED drive; reset beats mode change beats step.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode    <= MODE_COUNT;
      div_cnt <= '0;
      LED     <= 8'h00;
    end else if (mode_change) begin
      mode    <= mode_t'(choose);
      div_cnt <= '0;
      LED     <= led_seed;
    end else if (tick) begin
      div_cnt <= '0;
      LED     <= led_step;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_test_led_ctrl.sv
// Directed bench for test_led_ctrl: one instance with DIV_COUNT=1 for the
// pattern sequences, one with DIV_COUNT=4 for the step interval.
module tb_test_led_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] choose;
  logic [7:0] led;
  logic       rst4;
  logic [1:0] choose4;
  logic [7:0] led4;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  test_led_ctrl #(.DIV_COUNT(1)) dut (
    .clk    (clk),
    .rst    (rst),
    .choose (choose),
    .LED    (led)
  );

  test_led_ctrl #(.DIV_COUNT(4)) dut4 (
    .clk    (clk),
    .rst    (rst4),
    .choose (choose4),
    .LED    (led4)
  );

  // Advance one edge and settle; inputs are changed only after this returns.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] exp_seq [3];
    rst = 1'b1; choose = 2'd0;
    step();
    checks++;
    if (led !== 8'h00) begin
      failures++;
      $display("FAIL reset: LED=%h expected=%h", led, 8'h00);
    end
    rst = 1'b0;
    exp_seq = '{8'h01, 8'h02, 8'h03};
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (led !== exp_seq[i]) begin
        failures++;
        $display("FAIL count_start[%0d]: LED=%h expected=%h", i, led, exp_seq[i]);
      end
    end
  endtask

  task automatic test_rotl();
    logic [7:0] exp_seq [9];
    choose = 2'd1;
    exp_seq = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
    for (int i = 0; i < 9; i++) begin
      step();
      checks++;
      if (led !== exp_seq[i]) begin
        failures++;
        $display("FAIL rotl[%0d]: LED=%h expected=%h", i, led, exp_seq[i]);
      end
    end
  endtask

  task automatic test_rotr_flash();
    logic [7:0] exp_r [9];
    logic [7:0] exp_f [4];
    choose = 2'd2;
    exp_r = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h80};
    for (int i = 0; i < 9; i++) begin
      step();
      checks++;
      if (led !== exp_r[i]) begin
        failures++;
        $display("FAIL rotr[%0d]: LED=%h expected=%h", i, led, exp_r[i]);
      end
    end
    choose = 2'd3;
    exp_f = '{8'hFF, 8'h00, 8'hFF, 8'h00};
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (led !== exp_f[i]) begin
        failures++;
        $display("FAIL flash[%0d]: LED=%h expected=%h", i, led, exp_f[i]);
      end
    end
  endtask

  task automatic test_reseed_and_reset();
    choose = 2'd2;
    step();
    checks++;
    if (led !== 8'h80) begin
      failures++;
      $display("FAIL reseed: LED=%h expected=%h", led, 8'h80);
    end
    step();
    checks++;
    if (led !== 8'h40) begin
      failures++;
      $display("FAIL reseed_step: LED=%h expected=%h", led, 8'h40);
    end
    rst = 1'b1;
    step();
    checks++;
    if (led !== 8'h00) begin
      failures++;
      $display("FAIL mid_reset: LED=%h expected=%h", led, 8'h00);
    end
    rst = 1'b0;
    step();
    checks++;
    if (led !== 8'h80) begin
      failures++;
      $display("FAIL reset_release_mode2: LED=%h expected=%h", led, 8'h80);
    end
  endtask

  task automatic test_count_wrap();
    logic [7:0] exp_v;
    choose = 2'd0;
    step();
    checks++;
    if (led !== 8'h00) begin
      failures++;
      $display("FAIL count_seed: LED=%h expected=%h", led, 8'h00);
    end
    exp_v = 8'h00;
    for (int i = 0; i < 256; i++) begin
      step();
      exp_v = exp_v + 8'd1;
      checks++;
      if (led !== exp_v) begin
        failures++;
        $display("FAIL count_wrap[%0d]: LED=%h expected=%h", i, led, exp_v);
      end
    end
    checks++;
    if (led !== 8'h00) begin
      failures++;
      $display("FAIL count_wrap_end: LED=%h expected=%h", led, 8'h00);
    end
  endtask

  task automatic test_div4();
    logic [7:0] exp_a [10];
    logic [7:0] exp_b [5];
    rst4 = 1'b1; choose4 = 2'd0;
    step();
    checks++;
    if (led4 !== 8'h00) begin
      failures++;
      $display("FAIL div4_reset: LED=%h expected=%h", led4, 8'h00);
    end
    rst4 = 1'b0; choose4 = 2'd1;
    exp_a = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h02, 8'h02, 8'h02, 8'h02, 8'h04, 8'h04};
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (led4 !== exp_a[i]) begin
        failures++;
        $display("FAIL div4_hold[%0d]: LED=%h expected=%h", i, led4, exp_a[i]);
      end
    end
    // Two clocks into the 04 interval: change mode, seed loads and interval restarts.
    choose4 = 2'd2;
    exp_b = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h40};
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (led4 !== exp_b[i]) begin
        failures++;
        $display("FAIL div4_change[%0d]: LED=%h expected=%h", i, led4, exp_b[i]);
      end
    end
  endtask

  initial begin
    rst = 1'b1; choose = 2'd0;
    rst4 = 1'b1; choose4 = 2'd0;
    #1;
    test_reset();
    test_rotl();
    test_rotr_flash();
    test_reseed_and_reset();
    test_count_wrap();
    test_div4();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time=%0t limit=%0d", $time, 100000);
    $fatal(1, "watchdog expired");
  end

endmodule
